imem_responder: RTL and testbench

Instruction-memory responder serving the fetch stage's read requests over a valid/ready request/response handshake. It models a multi-cycle instruction store: it accepts one word-aligned byte address, waits a fixed latency, then returns the addressed 32-bit word. Misaligned and out-of-range addresses return an error instead of data. A side load port writes program words. It sits between the fetch-stage PC logic and the instruction storage, replacing the combinational array read.

---
 rtl/imem_if.sv | 22 ++
 rtl/imem_responder.sv | 140 ++++++++++++++
 tb/tb_imem_responder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Fetch-side request/response bundle for the instruction-memory responder.
// The master is the fetch stage and the slave is the responder.
interface imem_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        abort;

  modport master (
    output req_valid, req_addr, resp_ready, abort,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, abort,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Multi-cycle instruction store answering one fetch request at a time.
// A request is accepted in IDLE, waits out the configured latency in WAIT,
// and its word (or an error) is presented in RESP until consumed or flushed.
// All handshake outputs are registers, so no input reaches an output
// combinationally.
module imem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_if.slave                    bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int IDX_W = $clog2(DEPTH);

  // WAIT counts down from LATENCY-2 so the capture lands on the LATENCY-th
  // edge after acceptance (the acceptance edge is the first).
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_reg;
  logic [3:0]         count_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               err_reg;
  logic [31:0]        resp_data_reg;
  logic               resp_err_reg;
  logic               req_ready_reg;
  logic               resp_valid_reg;

  // Program storage; contents survive reset and are only changed by loads.
  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic               req_err;

  // Decode the incoming address: low bits must be zero and the word index
  // must fall inside the store, otherwise the request is answered with an error.
  always_comb begin
    req_idx = bus.req_addr[IDX_W+1:2];
    req_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= 30'(DEPTH));
  end

  // Program-load write port, active in every state and during reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Request/response state machine with registered handshake outputs.
  // The word is read from the array on the capture edge, so a load on that
  // same edge is not seen while a load on any earlier edge is.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= 4'd0;
      idx_reg        <= '0;
      err_reg        <= 1'b0;
      resp_data_reg  <= 32'd0;
      resp_err_reg   <= 1'b0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && !bus.abort) begin
            idx_reg       <= req_idx;
            err_reg       <= req_err;
            req_ready_reg <= 1'b0;
            if (LATENCY == 1) begin
              resp_data_reg  <= req_err ? 32'd0 : mem[req_idx];
              resp_err_reg   <= req_err;
              resp_valid_reg <= 1'b1;
              state_reg      <= RESP;
            end else begin
              count_reg <= CNT_INIT;
              state_reg <= WAIT;
            end
          end
        end

        WAIT: begin
          if (bus.abort) begin
            // Flushed before the word was captured: drop it silently.
            count_reg     <= 4'd0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
          end else begin
            resp_data_reg  <= err_reg ? 32'd0 : mem[idx_reg];
            resp_err_reg   <= err_reg;
            resp_valid_reg <= 1'b1;
            state_reg      <= RESP;
          end
        end

        RESP: begin
          // Abort and consumption both end the response; data stays held.
          if (bus.abort || bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end

        default: begin
          count_reg      <= 4'd0;
          resp_valid_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.resp_err   = resp_err_reg;

  // Accepting a request and offering a response never overlap.
  a_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.req_ready && bus.resp_valid));

  // A response that is neither consumed nor flushed keeps its payload.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.resp_valid && !bus.resp_ready && !bus.abort)
      |=> (bus.resp_valid && $stable(bus.resp_data) && $stable(bus.resp_err)));

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder. Two instances run side by
// side (latency 2 and 3) sharing reset and the load port; a transaction-level
// reference model predicts every output on every cycle.
module tb_imem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;
  localparam int LAT1  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        vld  [2];
  logic [31:0] addr [2];
  logic        rrdy [2];
  logic        abt  [2];

  always #5 clk = ~clk;

  imem_if bus0();
  imem_if bus1();

  assign bus0.req_valid  = vld[0];
  assign bus0.req_addr   = addr[0];
  assign bus0.resp_ready = rrdy[0];
  assign bus0.abort      = abt[0];
  assign bus1.req_valid  = vld[1];
  assign bus1.req_addr   = addr[1];
  assign bus1.resp_ready = rrdy[1];
  assign bus1.abort      = abt[1];

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // Reference model: a request is "outstanding" until its due edge, at which
  // point the word (as stored before that edge's load) becomes the response.
  logic [31:0] ref_mem [DEPTH];
  bit          outstanding [2];
  bit          holding     [2];
  int          due         [2];
  logic [29:0] p_word      [2];
  bit          p_err       [2];
  logic [31:0] exp_data    [2];
  bit          exp_err     [2];
  int          cyc;

  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic obs_ready(input int i);
    return (i == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic logic obs_valid(input int i);
    return (i == 0) ? bus0.resp_valid : bus1.resp_valid;
  endfunction
  function automatic logic [31:0] obs_data(input int i);
    return (i == 0) ? bus0.resp_data : bus1.resp_data;
  endfunction
  function automatic logic obs_err(input int i);
    return (i == 0) ? bus0.resp_err : bus1.resp_err;
  endfunction

  task automatic deliver(input int i);
    outstanding[i] = 0;
    holding[i]     = 1;
    exp_err[i]     = p_err[i];
    exp_data[i]    = p_err[i] ? 32'd0 : ref_mem[p_word[i][9:0]];
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    int lat;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? LAT0 : LAT1;
      if (rst) begin
        outstanding[i] = 0;
        holding[i]     = 0;
        exp_data[i]    = 32'd0;
        exp_err[i]     = 0;
      end else if (outstanding[i]) begin
        if (abt[i]) outstanding[i] = 0;
        else if (cyc == due[i]) deliver(i);
      end else if (holding[i]) begin
        if (abt[i] || rrdy[i]) holding[i] = 0;
      end else if (vld[i] && !abt[i]) begin
        p_word[i]      = addr[i][31:2];
        p_err[i]       = (addr[i][1:0] != 2'b00) || (int'(addr[i][31:2]) >= DEPTH);
        due[i]         = cyc + lat - 1;
        outstanding[i] = 1;
        if (due[i] == cyc) deliver(i);
      end
    end
    if (load_en) ref_mem[load_addr] = load_data;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ready%0d", i), 32'(obs_ready(i)), 32'(!outstanding[i] && !holding[i]));
        check($sformatf("valid%0d", i), 32'(obs_valid(i)), 32'(holding[i]));
        check($sformatf("data%0d", i),  obs_data(i), exp_data[i]);
        check($sformatf("err%0d", i),   32'(obs_err(i)), 32'(exp_err[i]));
      end
    end
  endtask

  // Issue one request on instance i and wait (bounded) for its response.
  task automatic fetch(input int i, input logic [31:0] a, output int edges);
    vld[i]  = 1'b1;
    addr[i] = a;
    tick();
    vld[i]  = 1'b0;
    edges   = 1;
    while (!obs_valid(i) && edges < 40) begin
      tick();
      edges++;
    end
    check($sformatf("resp_timeout%0d", i), 32'(obs_valid(i)), 32'd1);
    $display("fetch inst=%0d addr=%08h edges=%0d data=%08h err=%0b",
             i, a, edges, obs_data(i), obs_err(i));
  endtask

  initial begin
    int e;
    cyc       = 0;
    rst       = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; addr[i] = '0; rrdy[i] = 1'b1; abt[i] = 1'b0;
      outstanding[i] = 0; holding[i] = 0; exp_data[i] = '0; exp_err[i] = 0;
      due[i] = 0; p_word[i] = '0; p_err[i] = 0;
    end

    // Program load (under reset), with mem[1] = 0x8001060A.
    load_en = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      load_addr = 10'(w);
      load_data = (w == 1) ? 32'h8001_060A : $urandom;
      tick();
    end
    load_en = 1'b0;
    tick();
    chk_en = 1;
    check("reset_ready", 32'(bus0.req_ready), 32'd1);
    check("reset_valid", 32'(bus0.resp_valid), 32'd0);
    check("reset_data",  bus0.resp_data, 32'd0);
    rst = 1'b0;
    tick();

    // Aligned fetch, latency 2.
    fetch(0, 32'h4, e);
    check("lat2_edges", 32'(e), 32'd2);
    check("aligned_data", bus0.resp_data, 32'h8001_060A);
    check("aligned_err", 32'(bus0.resp_err), 32'd0);
    tick();

    // Back-pressure.
    rrdy[0] = 1'b0;
    fetch(0, 32'h8, e);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(bus0.resp_valid), 32'd1);
      check("bp_data",  bus0.resp_data, ref_mem[2]);
      check("bp_ready", 32'(bus0.req_ready), 32'd0);
    end
    rrdy[0] = 1'b1;
    tick();
    check("bp_release_ready", 32'(bus0.req_ready), 32'd1);
    check("bp_release_valid", 32'(bus0.resp_valid), 32'd0);

    // Errors and the last in-range word.
    fetch(0, 32'h6, e);
    check("misalign_err",  32'(bus0.resp_err), 32'd1);
    check("misalign_data", bus0.resp_data, 32'd0);
    tick();
    fetch(0, 32'h1000, e);
    check("range_err", 32'(bus0.resp_err), 32'd1);
    tick();
    fetch(0, 32'hFFC, e);
    check("last_err",  32'(bus0.resp_err), 32'd0);
    check("last_data", bus0.resp_data, ref_mem[1023]);
    tick();

    // Abort in WAIT, then a normal fetch.
    vld[0] = 1'b1; addr[0] = 32'hC;
    tick();
    vld[0] = 1'b0; abt[0] = 1'b1;
    tick();
    abt[0] = 1'b0;
    check("abort_ready", 32'(bus0.req_ready), 32'd1);
    check("abort_valid", 32'(bus0.resp_valid), 32'd0);
    tick();
    tick();
    check("abort_no_resp", 32'(bus0.resp_valid), 32'd0);
    fetch(0, 32'h10, e);
    check("after_abort_data", bus0.resp_data, ref_mem[4]);
    tick();

    // Abort in RESP, and abort blocking acceptance in IDLE.
    rrdy[0] = 1'b0;
    fetch(0, 32'h14, e);
    abt[0] = 1'b1;
    tick();
    check("abort_resp_valid", 32'(bus0.resp_valid), 32'd0);
    vld[0] = 1'b1; addr[0] = 32'h18;
    tick();
    check("abort_idle_ready", 32'(bus0.req_ready), 32'd1);
    vld[0] = 1'b0; abt[0] = 1'b0; rrdy[0] = 1'b1;
    tick();

    // Reset while holding a nonzero response.
    rrdy[0] = 1'b0;
    fetch(0, 32'h4, e);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_resp_data",  bus0.resp_data, 32'd0);
    check("rst_resp_ready", 32'(bus0.req_ready), 32'd1);
    rrdy[0] = 1'b1;
    tick();

    // Load/read hazard on the latency-3 instance.
    vld[1] = 1'b1; addr[1] = 32'h8;
    tick();
    vld[1] = 1'b0;
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    tick();
    check("hazard_early_valid", 32'(bus1.resp_valid), 32'd1);
    check("hazard_early_data",  bus1.resp_data, 32'hDEAD_BEEF);
    tick();
    vld[1] = 1'b1; addr[1] = 32'h8;
    tick();
    vld[1] = 1'b0;
    tick();
    load_en = 1'b1; load_addr = 10'd2; load_data = 32'h1234_5678;
    tick();
    load_en = 1'b0;
    check("hazard_capture_data", bus1.resp_data, 32'hDEAD_BEEF);
    tick();
    fetch(1, 32'h8, e);
    check("lat3_edges", 32'(e), 32'd3);
    check("hazard_after_data", bus1.resp_data, 32'h1234_5678);
    tick();

    // Randomized traffic on both instances against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i]  = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
          0:       addr[i] = {20'd0, 10'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
          1:       addr[i] = {$urandom_range(DEPTH, 32'h3FFF_FFFF), 2'b00};
          default: addr[i] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        endcase
        rrdy[i] = ($urandom_range(0, 9) < 7);
        abt[i]  = ($urandom_range(0, 19) == 0);
      end
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = 10'($urandom_range(0, 15));
      load_data = $urandom;
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
